// File: rtl/sockit_pkg.sv
// Shared helpers for the sockit FIFOs: counter width and non-power-of-two pointer wrap.
package sockit_pkg;

  function automatic int unsigned sockit_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Pointers wrap from fd-1 back to 0 by compare, so any depth works.
  function automatic int unsigned inc_wrap(input int unsigned ptr, input int unsigned fd);
    return (ptr == fd - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sockit_fifo_mem.sv
// FIFO storage: FD x DW register array, one write port, one asynchronous read port, no reset.
module sockit_fifo_mem
  import sockit_pkg::*;
#(
  parameter int FD = 4,
  parameter int DW = 8,
  localparam int PW = sockit_clog2(FD)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [PW-1:0] ra,
  output logic [DW-1:0] rd
);

  logic [DW-1:0] mem_q [FD];

  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end

  assign rd = mem_q[ra];

endmodule

// File: rtl/sockit_fifo.sv
// Single-clock sockit request/grant FIFO with level, almost-full/empty flags and flush.
// Optional zero-latency bypass when empty is enabled by defining SOCKIT_FIFO_BYPASS_EN.
module sockit_fifo
  import sockit_pkg::*;
#(
  parameter int FD = 4,
  parameter int DW = 8,
  parameter int AF = FD - 1,
  parameter int AE = 1,
  localparam int CW = sockit_clog2(FD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ffi_clr,
  input  logic [DW-1:0] ffi_bus,
  input  logic          ffi_req,
  output logic          ffi_grt,
  output logic          ffi_afl,
  output logic [DW-1:0] ffo_bus,
  output logic          ffo_req,
  input  logic          ffo_grt,
  output logic          ffo_aem,
  output logic [CW-1:0] ffo_lvl
);

  localparam int PW = sockit_clog2(FD);
  localparam logic [CW-1:0] FD_L = CW'(FD);
  localparam logic [CW-1:0] AF_L = CW'(AF);
  localparam logic [CW-1:0] AE_L = CW'(AE);

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          full;
  logic          empty;
  logic          ffi_trn;
  logic          ffo_trn;
  logic          pass;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] mem_rd;

  assign full  = (cnt_q == FD_L);
  assign empty = (cnt_q == '0);

  assign ffi_grt = ~full & ~ffi_clr & ~rst;

`ifdef SOCKIT_FIFO_BYPASS_EN
  // While empty the write port is presented straight to the read side.
  assign ffo_req = (empty ? ffi_req : 1'b1) & ~ffi_clr & ~rst;
  assign ffo_bus = empty ? ffi_bus : mem_rd;
  assign pass    = empty & ffi_req & ffo_grt & ~ffi_clr & ~rst;
`else
  assign ffo_req = ~empty & ~ffi_clr & ~rst;
  assign ffo_bus = mem_rd;
  assign pass    = 1'b0;
`endif

  assign ffi_trn = ffi_req & ffi_grt;
  assign ffo_trn = ffo_req & ffo_grt;

  // A passed-through word is neither stored nor read from memory.
  assign wr_en = ffi_trn & ~pass;
  assign rd_en = ffo_trn & ~pass;

  assign ffi_afl = (cnt_q >= AF_L);
  assign ffo_aem = (cnt_q <= AE_L);
  assign ffo_lvl = cnt_q;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (ffi_clr) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (wr_en) wp_d = PW'(inc_wrap(32'(wp_q), FD));
      if (rd_en) rp_d = PW'(inc_wrap(32'(rp_q), FD));
      case ({wr_en, rd_en})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  sockit_fifo_mem #(
    .FD (FD),
    .DW (DW)
  ) u_mem (
    .clk (clk),
    .we  (wr_en),
    .wa  (wp_q),
    .wd  (ffi_bus),
    .ra  (rp_q),
    .rd  (mem_rd)
  );

endmodule

// File: tb/tb_sockit_fifo.sv
// Directed bench for sockit_fifo: a depth-4 instance and a depth-5 instance share clock and reset.
module tb_sockit_fifo;

  logic clk;
  logic rst;

  // depth 4, AF=3, AE=1
  logic       a_clr, a_req, a_grt, a_afl, a_oreq, a_ogrt, a_aem;
  logic [7:0] a_bus, a_obus;
  logic [2:0] a_lvl;

  // depth 5, AF=4, AE=1
  logic       b_clr, b_req, b_grt, b_afl, b_oreq, b_ogrt, b_aem;
  logic [7:0] b_bus, b_obus;
  logic [2:0] b_lvl;

  int n_cmp;
  int n_fail;

  sockit_fifo #(.FD(4), .DW(8), .AF(3), .AE(1)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .ffi_clr (a_clr),
    .ffi_bus (a_bus),
    .ffi_req (a_req),
    .ffi_grt (a_grt),
    .ffi_afl (a_afl),
    .ffo_bus (a_obus),
    .ffo_req (a_oreq),
    .ffo_grt (a_ogrt),
    .ffo_aem (a_aem),
    .ffo_lvl (a_lvl)
  );

  sockit_fifo #(.FD(5), .DW(8), .AF(4), .AE(1)) dut5 (
    .clk     (clk),
    .rst     (rst),
    .ffi_clr (b_clr),
    .ffi_bus (b_bus),
    .ffi_req (b_req),
    .ffi_grt (b_grt),
    .ffi_afl (b_afl),
    .ffo_bus (b_obus),
    .ffo_req (b_oreq),
    .ffo_grt (b_ogrt),
    .ffo_aem (b_aem),
    .ffo_lvl (b_lvl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_req = 1'b1;
    b_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (a_grt !== 1'b0) begin n_fail++; $display("FAIL rst_grt%0d got %b want 0", i, a_grt); end
    end
    n_cmp++;
    if (a_lvl !== 3'd0) begin n_fail++; $display("FAIL rst_lvl got %0d want 0", a_lvl); end
    n_cmp++;
    if (a_aem !== 1'b1) begin n_fail++; $display("FAIL rst_aem got %b want 1", a_aem); end
    n_cmp++;
    if (a_afl !== 1'b0) begin n_fail++; $display("FAIL rst_afl got %b want 0", a_afl); end
    n_cmp++;
    if (a_oreq !== 1'b0) begin n_fail++; $display("FAIL rst_oreq got %b want 0", a_oreq); end
    a_req = 1'b0;
    b_req = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (a_grt !== 1'b1) begin n_fail++; $display("FAIL rst_release_grt got %b want 1", a_grt); end
    n_cmp++;
    if (a_lvl !== 3'd0) begin n_fail++; $display("FAIL rst_release_lvl got %0d want 0", a_lvl); end
  endtask

  task automatic test_fill_drain();
    b_ogrt = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      b_bus = 8'(i);
      b_req = 1'b1;
      #1;
      n_cmp++;
      if (b_grt !== 1'b1) begin n_fail++; $display("FAIL fill_grt%0d got %b want 1", i, b_grt); end
      n_cmp++;
      if (b_afl !== (i - 1 >= 4)) begin n_fail++; $display("FAIL fill_afl%0d got %b want %b", i, b_afl, (i - 1 >= 4)); end
      step();
      n_cmp++;
      if (b_lvl !== 3'(i)) begin n_fail++; $display("FAIL fill_lvl%0d got %0d want %0d", i, b_lvl, i); end
    end
    n_cmp++;
    if (b_grt !== 1'b0) begin n_fail++; $display("FAIL full_grt got %b want 0", b_grt); end
    n_cmp++;
    if (b_afl !== 1'b1) begin n_fail++; $display("FAIL full_afl got %b want 1", b_afl); end
    n_cmp++;
    if (b_aem !== 1'b0) begin n_fail++; $display("FAIL full_aem got %b want 0", b_aem); end
    b_req = 1'b0;
    b_ogrt = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      #1;
      n_cmp++;
      if (b_oreq !== 1'b1) begin n_fail++; $display("FAIL drain_req%0d got %b want 1", i, b_oreq); end
      n_cmp++;
      if (b_obus !== 8'(i)) begin n_fail++; $display("FAIL drain_data%0d got %h want %h", i, b_obus, 8'(i)); end
      step();
    end
    b_ogrt = 1'b0;
    #1;
    n_cmp++;
    if (b_lvl !== 3'd0) begin n_fail++; $display("FAIL drain_lvl got %0d want 0", b_lvl); end
    n_cmp++;
    if (b_aem !== 1'b1) begin n_fail++; $display("FAIL drain_aem got %b want 1", b_aem); end
    n_cmp++;
    if (b_oreq !== 1'b0) begin n_fail++; $display("FAIL drain_oreq got %b want 0", b_oreq); end
  endtask

  task automatic test_wrap();
    int sent;
    int rcvd;
    int cyc;
    int errs;
    logic wtrn;
    logic rtrn;
    sent = 0;
    rcvd = 0;
    cyc = 0;
    errs = 0;
    while (rcvd < 203 && cyc < 4000) begin
      n_cmp++;
      if (b_lvl !== 3'(sent - rcvd)) begin
        n_fail++;
        errs++;
        if (errs < 10) $display("FAIL wrap_lvl c%0d got %0d want %0d", cyc, b_lvl, sent - rcvd);
      end
      if (cyc < 3) begin
        b_req = 1'b1;
        b_ogrt = 1'b0;
      end else if (cyc < 6) begin
        b_req = 1'b0;
        b_ogrt = 1'b1;
      end else begin
        b_req = (sent < 203) && ($urandom_range(1) == 1);
        b_ogrt = ($urandom_range(1) == 1);
      end
      b_bus = 8'(sent);
      #1;
      wtrn = b_req & b_grt;
      rtrn = b_oreq & b_ogrt;
      if (rtrn) begin
        n_cmp++;
        if (b_obus !== 8'(rcvd)) begin
          n_fail++;
          errs++;
          if (errs < 10) $display("FAIL wrap_data w%0d got %h want %h", rcvd, b_obus, 8'(rcvd));
        end
      end
      step();
      if (wtrn) sent++;
      if (rtrn) rcvd++;
      cyc++;
    end
    b_req = 1'b0;
    b_ogrt = 1'b0;
    n_cmp++;
    if (rcvd != 203) begin n_fail++; $display("FAIL wrap_timeout got %0d words want 203", rcvd); end
  endtask

  task automatic test_full_read();
    a_ogrt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_bus = 8'h10 + 8'(i);
      a_req = 1'b1;
      step();
    end
    a_bus = 8'h77;
    a_req = 1'b1;
    a_ogrt = 1'b1;
    #1;
    n_cmp++;
    if (a_grt !== 1'b0) begin n_fail++; $display("FAIL fullrd_grt got %b want 0", a_grt); end
    n_cmp++;
    if (a_obus !== 8'h10) begin n_fail++; $display("FAIL fullrd_data got %h want 10", a_obus); end
    step();
    a_ogrt = 1'b0;
    #1;
    n_cmp++;
    if (a_lvl !== 3'd3) begin n_fail++; $display("FAIL fullrd_lvl got %0d want 3", a_lvl); end
    n_cmp++;
    if (a_grt !== 1'b1) begin n_fail++; $display("FAIL fullrd_next_grt got %b want 1", a_grt); end
    a_req = 1'b0;
    a_ogrt = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      n_cmp++;
      if (a_obus !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL fullrd_rest%0d got %h want %h", i, a_obus, 8'h10 + 8'(i)); end
      step();
    end
    a_ogrt = 1'b0;
    #1;
    n_cmp++;
    if (a_lvl !== 3'd0) begin n_fail++; $display("FAIL fullrd_end_lvl got %0d want 0", a_lvl); end
  endtask

  task automatic test_flush();
    a_ogrt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_bus = 8'h21 + 8'(i);
      a_req = 1'b1;
      step();
    end
    n_cmp++;
    if (a_lvl !== 3'd3) begin n_fail++; $display("FAIL flush_pre_lvl got %0d want 3", a_lvl); end
    a_clr = 1'b1;
    a_bus = 8'h99;
    a_req = 1'b1;
    a_ogrt = 1'b1;
    #1;
    n_cmp++;
    if (a_grt !== 1'b0) begin n_fail++; $display("FAIL flush_grt got %b want 0", a_grt); end
    n_cmp++;
    if (a_oreq !== 1'b0) begin n_fail++; $display("FAIL flush_oreq got %b want 0", a_oreq); end
    step();
    a_clr = 1'b0;
    a_req = 1'b0;
    a_ogrt = 1'b0;
    #1;
    n_cmp++;
    if (a_lvl !== 3'd0) begin n_fail++; $display("FAIL flush_lvl got %0d want 0", a_lvl); end
    n_cmp++;
    if (a_oreq !== 1'b0) begin n_fail++; $display("FAIL flush_post_oreq got %b want 0", a_oreq); end
    n_cmp++;
    if (a_grt !== 1'b1) begin n_fail++; $display("FAIL flush_post_grt got %b want 1", a_grt); end
    a_bus = 8'h55;
    a_req = 1'b1;
    step();
    a_req = 1'b0;
    a_ogrt = 1'b1;
    #1;
    n_cmp++;
    if (a_obus !== 8'h55) begin n_fail++; $display("FAIL flush_after_data got %h want 55", a_obus); end
    step();
    a_ogrt = 1'b0;
    #1;
    n_cmp++;
    if (a_lvl !== 3'd0) begin n_fail++; $display("FAIL flush_after_lvl got %0d want 0", a_lvl); end
  endtask

  task automatic test_bypass();
    a_bus = 8'hA5;
    a_req = 1'b1;
    a_ogrt = 1'b1;
    #1;
`ifdef SOCKIT_FIFO_BYPASS_EN
    n_cmp++;
    if (a_oreq !== 1'b1) begin n_fail++; $display("FAIL byp_oreq got %b want 1", a_oreq); end
    n_cmp++;
    if (a_obus !== 8'hA5) begin n_fail++; $display("FAIL byp_data got %h want a5", a_obus); end
    step();
    a_req = 1'b0;
    a_ogrt = 1'b0;
    #1;
    n_cmp++;
    if (a_lvl !== 3'd0) begin n_fail++; $display("FAIL byp_lvl got %0d want 0", a_lvl); end
`else
    n_cmp++;
    if (a_oreq !== 1'b0) begin n_fail++; $display("FAIL byp_oreq got %b want 0", a_oreq); end
    step();
    a_req = 1'b0;
    a_ogrt = 1'b0;
    #1;
    n_cmp++;
    if (a_lvl !== 3'd1) begin n_fail++; $display("FAIL byp_lvl got %0d want 1", a_lvl); end
    n_cmp++;
    if (a_oreq !== 1'b1) begin n_fail++; $display("FAIL byp_late_oreq got %b want 1", a_oreq); end
    n_cmp++;
    if (a_obus !== 8'hA5) begin n_fail++; $display("FAIL byp_late_data got %h want a5", a_obus); end
    a_ogrt = 1'b1;
    step();
    a_ogrt = 1'b0;
    #1;
    n_cmp++;
    if (a_lvl !== 3'd0) begin n_fail++; $display("FAIL byp_end_lvl got %0d want 0", a_lvl); end
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    a_clr = 1'b0; a_req = 1'b0; a_bus = 8'h00; a_ogrt = 1'b0;
    b_clr = 1'b0; b_req = 1'b0; b_bus = 8'h00; b_ogrt = 1'b0;
    #1;
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_read();
    test_flush();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sockit_fifo.md
# sockit_fifo

Single-clock, parametrised-depth FIFO using the sockit request/grant handshake on both ports. It is the synchronous sibling of the clock-domain-crossing FIFO, for buffering between blocks that share one clock. Depth is not restricted to a power of two. It adds a fill-level output, almost-full/almost-empty flags, a synchronous flush and an optional zero-latency bypass.

## Interface
- `FD`, 4: depth in entries, ≥ 2, any integer.
- `DW`, 8: data width.
- `AF`, FD-1: almost-full threshold, 1..FD.
- `AE`, 1: almost-empty threshold, 0..FD-1.
- `CW` (localparam), clog2(FD+1): level width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous active-high reset.
- `ffi_clr`  in  1  synchronous flush.
- `ffi_bus`  in  DW  write data.
- `ffi_req`  in  1  write request.
- `ffi_grt`  out  1  write grant.
- `ffi_afl`  out  1  almost full: level ≥ AF.
- `ffo_bus`  out  DW  read data.
- `ffo_req`  out  1  read request (data valid).
- `ffo_grt`  in  1  read grant.
- `ffo_aem`  out  1  almost empty: level ≤ AE.
- `ffo_lvl`  out  CW  current number of stored entries, 0..FD.

## Operation
- A transfer happens on a port when req & grt are both high at a rising edge. ffi_trn writes; ffo_trn reads.
- `ffi_grt` = ~full & ~ffi_clr & ~rst. `ffo_req` = ~empty & ~ffi_clr & ~rst. Neither depends on the opposite port's handshake input, so there is no combinational loop through the FIFO.
- Pointers `wp` and `rp` each run 0..FD-1. They wrap from FD-1 to 0 by explicit compare, not power-of-two overflow.
- Level counter `cnt`:
  - +1 on write only.
  - −1 on read only.
  - Unchanged on simultaneous write and read.
  - full = (cnt == FD); empty = (cnt == 0).
- When full, writes are refused even if a read occurs in the same cycle. `ffi_grt` stays low for that cycle.
- When both ports transfer at an intermediate level, both pointers advance and `cnt` holds.
- `ffo_bus` = mem[rp]. Its value is undefined while `ffo_req` is low; the bench must not check it then.
- `ffi_clr`:
  - Pointers and `cnt` go to 0 at the edge.
  - Grants/requests are masked in that cycle, so no transfer occurs.
  - Memory contents are untouched.
- Flags and `ffo_lvl` are combinational from `cnt` only.

## Timing
- Reset values, during and after `rst` high: wp = rp = cnt = 0; ffi_grt = 0; ffo_req = 0; ffo_lvl = 0; ffi_afl = (AF == 0 ? 1 : 0) → 0; ffo_aem = 1. Memory is not reset.
- First cycle after `rst` falls: ffi_grt = 1.
- Reset or flush mid-operation discards all contents in one cycle. There is no drain.
- Write-to-read latency without bypass is 1 cycle. A word written at edge N raises `ffo_req` after edge N and can be read at edge N+1.
- Level and flags update one edge after the causing transfer.
- Throughput: one write and one read per cycle sustained, at any level 1..FD-1.

## Configuration
- `SOCKIT_FIFO_BYPASS_EN` defined:
  - When empty, `ffo_req` = ffi_req and `ffo_bus` = ffi_bus combinationally.
  - If both ffi_req and ffo_grt are high while empty, the word passes straight through: no write, wp and cnt unchanged.
  - If ffo_grt is low, the word is stored normally.
  - ffo_lvl/flags still reflect stored entries only.
  - This creates a combinational path ffi_req/ffi_bus → ffo_req/ffo_bus.
- Undefined: `ffo_req` depends only on `cnt`. Latency is strictly 1 cycle and there is no input-to-output combinational path.

## Structure
- Shared package `sockit_pkg` holds:
  - the counter-width function (clog2), used for CW and pointer width;
  - the wrap-increment function `inc_wrap(ptr, FD)`.
- Sub-module `sockit_fifo_mem`:
  - FD×DW register array with one write port (we, wa, wd) and one asynchronous read port (ra, rd);
  - no reset.
- Top level holds the pointers, counter, flags, flush and bypass logic.

## Test plan
- Reset: FD=4. Hold `rst` 3 cycles. All outputs are at reset values (ffi_grt=0, ffo_lvl=0, ffo_aem=1). ffi_grt=1 on the first cycle after release.
- Fill/drain with FD=5 (non-power-of-two), ffo_grt=0:
  - write 0x01..0x05 → ffi_grt=0 after the 5th write, ffo_lvl=5, ffi_afl=1 (AF=4);
  - then ffo_grt=1 → reads 0x01..0x05 in order, ffo_lvl reaches 0, ffo_aem=1.
- Wrap: FD=5. Run 3 writes and 3 reads, then 200 words with random req/grt at 50 % probability, counter pattern data → no mismatch, no loss. Pointers pass 4→0 repeatedly.
- Full + read: FD=4 full, ffi_req=1, ffo_grt=1 one cycle → one read, no write, ffo_lvl=3; next cycle ffi_grt=1.
- Flush: level 3, assert ffi_clr with ffi_req=ffo_grt=1 → no transfer that cycle, next cycle ffo_lvl=0, ffo_req=0, ffi_grt=1.
- Bypass (macro defined): empty, ffi_req=1, ffi_bus=0xA5, ffo_grt=1 → same cycle ffo_req=1 and ffo_bus=0xA5, ffo_lvl stays 0. Without the macro → ffo_req rises one cycle later and ffo_lvl=1.
